// File: rtl/clk_switch_pkg.sv
// Shared types and helpers for the clk_switch_n clock switch.
// Holds the FSM state encoding, park-polarity codes and the timeout counter sizing.
package clk_switch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DROP  = 2'd1,
    ST_RAISE = 2'd2
  } sw_state_e;

  localparam int PARK_LOW  = 0;
  localparam int PARK_HIGH = 1;

  function automatic int tmo_width(input int t);
    return (t < 2) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/clk_switch_chan.sv
// One source channel: enable latch, park-edge enable pipe and clock gate.
// The gate only changes while the source sits in its park phase, so the gated clock never runts.
module clk_switch_chan
  import clk_switch_pkg::*;
#(
  parameter int SYNC_DEPTH = 2,
  parameter int STOP_HIGH  = 1,
  parameter int RESET_ON   = 0
) (
  input  logic src_clk,
  input  logic reset_b,
  input  logic force_off,
  input  logic en_req,
  output logic gclk,
  output logic ack
);

  localparam bit PARK_IS_HIGH = (STOP_HIGH != PARK_LOW);
  localparam logic [SYNC_DEPTH-1:0] PIPE_INIT = (RESET_ON != 0) ? '1 : '0;
  localparam logic LAT_INIT = (RESET_ON != 0);

  // High exactly while the source is in its park phase; its rising edge enters that phase.
  logic park_clk;
  logic en_lat;
  logic [SYNC_DEPTH-1:0] pipe_q;
  logic [SYNC_DEPTH-1:0] pipe_d;
  logic pipe_last;

  assign park_clk = PARK_IS_HIGH ? src_clk : ~src_clk;

  always_latch begin
    if (!reset_b) begin
      en_lat <= LAT_INIT;
    end else if (park_clk) begin
      en_lat <= en_req;
    end
  end

  always_comb begin
    pipe_d = {pipe_q[SYNC_DEPTH-2:0], en_lat};
  end

  always_ff @(posedge park_clk or negedge reset_b or posedge force_off) begin
    if (!reset_b) begin
      pipe_q <= PIPE_INIT;
    end else if (force_off) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign pipe_last = pipe_q[SYNC_DEPTH-1];
  assign ack       = pipe_last;
  assign gclk      = PARK_IS_HIGH ? (src_clk | ~(pipe_last & en_lat))
                                  : (src_clk & pipe_last & en_lat);

endmodule

// File: rtl/clk_switch_n.sv
// Glitch-free run-time selection of one of NSRC asynchronous clocks onto clkout.
// hsclk runs the request handshake, break-before-make sequencing and dead-clock timeout.
module clk_switch_n
  import clk_switch_pkg::*;
#(
  parameter int NSRC       = 4,
  parameter int SELW       = 2,
  parameter int SYNC_DEPTH = 2,
  parameter int STOP_HIGH  = 1,
  parameter int RESET_SEL  = 0,
  parameter int TIMEOUT    = 255
) (
  input  logic            hsclk,
  input  logic            reset_b,
  input  logic [NSRC-1:0] src_clk,
  input  logic [SELW-1:0] sel_req,
  input  logic            sel_valid,
  output logic            sel_ready,
  output logic [SELW-1:0] cur_sel,
  output logic            busy,
  output logic            switch_done,
  output logic            timeout_err,
  output logic            clkout
);

  // state    | meaning
  // ST_IDLE  | cur_sel owns clkout; requests accepted
  // ST_DROP  | en_req[cur_sel] dropped; waiting for its ack to fall
  // ST_RAISE | en_req[new_sel] raised; waiting for its ack to rise

  localparam int TW = tmo_width(TIMEOUT);
  localparam logic [TW-1:0]   TMO_LOAD = TW'(TIMEOUT - 1);
  localparam logic [NSRC-1:0] RST_OH   = NSRC'(1) << RESET_SEL;
  localparam logic [SELW-1:0] RST_SEL  = SELW'(RESET_SEL);

  sw_state_e       state_q, state_d;
  logic [SELW-1:0] cur_sel_q, cur_sel_d;
  logic [SELW-1:0] new_sel_q, new_sel_d;
  logic [NSRC-1:0] en_req_q, en_req_d;
  logic [NSRC-1:0] force_off_q, force_off_d;
  logic            force_hold_q, force_hold_d;
  logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic            timeout_err_q, timeout_err_d;
  logic            switch_done_q, switch_done_d;
  logic [NSRC-1:0] ack_meta_q, ack_sync_q;

  logic [NSRC-1:0] gclk, ack;
  logic [NSRC-1:0] cur_oh, new_oh, req_oh;
  logic            ack_cur, ack_new;

  for (genvar k = 0; k < NSRC; k++) begin : g_chan
    clk_switch_chan #(
      .SYNC_DEPTH(SYNC_DEPTH),
      .STOP_HIGH (STOP_HIGH),
      .RESET_ON  ((k == RESET_SEL) ? 1 : 0)
    ) u_chan (
      .src_clk  (src_clk[k]),
      .reset_b  (reset_b),
      .force_off(force_off_q[k]),
      .en_req   (en_req_q[k]),
      .gclk     (gclk[k]),
      .ack      (ack[k])
    );
  end

  // Parked channels sit at the park level, so the live one passes through the reduction.
  assign clkout = (STOP_HIGH == PARK_HIGH) ? &gclk : |gclk;

  always_comb begin
    cur_oh = '0;
    new_oh = '0;
    req_oh = '0;
    for (int i = 0; i < NSRC; i++) begin
      cur_oh[i] = (cur_sel_q == SELW'(i));
      new_oh[i] = (new_sel_q == SELW'(i));
      req_oh[i] = (sel_req == SELW'(i));
    end
  end

  assign ack_cur = |(ack_sync_q & cur_oh);
  assign ack_new = |(ack_sync_q & new_oh);

  always_comb begin
    state_d       = state_q;
    cur_sel_d     = cur_sel_q;
    new_sel_d     = new_sel_q;
    en_req_d      = en_req_q;
    timeout_err_d = timeout_err_q;
    switch_done_d = 1'b0;
    tmo_cnt_d     = (tmo_cnt_q != '0) ? tmo_cnt_q - TW'(1) : tmo_cnt_q;
    force_off_d   = force_hold_q ? force_off_q : '0;
    force_hold_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (sel_valid) begin
          if (sel_req == cur_sel_q) begin
            switch_done_d = 1'b1;
          end else if (|req_oh) begin
            new_sel_d = sel_req;
            en_req_d  = '0;
            tmo_cnt_d = TMO_LOAD;
            state_d   = ST_DROP;
          end
        end
      end
      ST_DROP: begin
        if (!ack_cur) begin
          en_req_d  = new_oh;
          tmo_cnt_d = TMO_LOAD;
          state_d   = ST_RAISE;
        end else if (tmo_cnt_q == '0) begin
          // Dead old source: clear its pipe so its gate falls back to the park level.
          timeout_err_d = 1'b1;
          force_off_d   = cur_oh;
          force_hold_d  = 1'b1;
          en_req_d      = new_oh;
          tmo_cnt_d     = TMO_LOAD;
          state_d       = ST_RAISE;
        end
      end
      ST_RAISE: begin
        if (ack_new || tmo_cnt_q == '0) begin
          timeout_err_d = timeout_err_q | ~ack_new;
          cur_sel_d     = new_sel_q;
          switch_done_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge hsclk or negedge reset_b) begin
    if (!reset_b) begin
      state_q       <= ST_IDLE;
      cur_sel_q     <= RST_SEL;
      new_sel_q     <= RST_SEL;
      en_req_q      <= RST_OH;
      force_off_q   <= '0;
      force_hold_q  <= 1'b0;
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
      switch_done_q <= 1'b0;
      ack_meta_q    <= RST_OH;
      ack_sync_q    <= RST_OH;
    end else begin
      state_q       <= state_d;
      cur_sel_q     <= cur_sel_d;
      new_sel_q     <= new_sel_d;
      en_req_q      <= en_req_d;
      force_off_q   <= force_off_d;
      force_hold_q  <= force_hold_d;
      tmo_cnt_q     <= tmo_cnt_d;
      timeout_err_q <= timeout_err_d;
      switch_done_q <= switch_done_d;
      ack_meta_q    <= ack;
      ack_sync_q    <= ack_meta_q;
    end
  end

  assign sel_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign cur_sel     = cur_sel_q;
  assign switch_done = switch_done_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_clk_switch_n.sv
// Directed bench for clk_switch_n: one park-high and one park-low instance on shared sources.
// Sources are 50/16/8/2 MHz, hsclk is 50 MHz; src_clk[2] can be stopped to exercise the timeout.
`timescale 1ns/1ps
module tb_clk_switch_n;

  logic hsclk = 1'b0;
  logic s0 = 1'b0, s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
  bit   run2 = 1'b1;
  logic [3:0] src_clk;

  always #10 hsclk = ~hsclk;
  initial begin #3;  forever #10    s0 = ~s0; end
  initial begin #7;  forever #31.25 s1 = ~s1; end
  initial begin #11; forever begin #62.5; if (run2 || s2) s2 = ~s2; end end
  initial begin #13; forever #250   s3 = ~s3; end
  assign src_clk = {s3, s2, s1, s0};

  logic       rst_h_b, sel_valid_h, sel_ready_h, busy_h, done_h, terr_h, clkout_h;
  logic [2:0] sel_req_h, cur_sel_h;
  logic       rst_l_b, sel_valid_l, sel_ready_l, busy_l, done_l, terr_l, clkout_l;
  logic [1:0] sel_req_l, cur_sel_l;

  clk_switch_n #(.NSRC(4), .SELW(3), .SYNC_DEPTH(2), .STOP_HIGH(1), .RESET_SEL(0), .TIMEOUT(255)) dut_h (
    .hsclk(hsclk), .reset_b(rst_h_b), .src_clk(src_clk), .sel_req(sel_req_h),
    .sel_valid(sel_valid_h), .sel_ready(sel_ready_h), .cur_sel(cur_sel_h), .busy(busy_h),
    .switch_done(done_h), .timeout_err(terr_h), .clkout(clkout_h));

  clk_switch_n #(.NSRC(4), .SELW(2), .SYNC_DEPTH(2), .STOP_HIGH(0), .RESET_SEL(0), .TIMEOUT(255)) dut_l (
    .hsclk(hsclk), .reset_b(rst_l_b), .src_clk(src_clk), .sel_req(sel_req_l),
    .sel_valid(sel_valid_l), .sel_ready(sel_ready_l), .cur_sel(cur_sel_l), .busy(busy_l),
    .switch_done(done_l), .timeout_err(terr_l), .clkout(clkout_l));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Phase-width monitor on the selected output clock.
  bit      mon_sel = 1'b0;
  bit      mon_en  = 1'b0;
  wire     mon_clk = mon_sel ? clkout_l : clkout_h;
  realtime last_edge = 0.0, min_ph = 1.0e9, max_hi = 0.0, max_lo = 0.0, w;

  always @(mon_clk) begin
    if (mon_en) begin
      w = $realtime - last_edge;
      if (w < min_ph) min_ph = w;
      if (!mon_clk && w > max_hi) max_hi = w;
      if (mon_clk && w > max_lo) max_lo = w;
    end
    last_edge = $realtime;
  end

  task automatic mon_start(input bit which);
    mon_sel = which;
    #1;
    min_ph = 1.0e9;
    max_hi = 0.0;
    max_lo = 0.0;
    mon_en = 1'b1;
  endtask

  int edges_h = 0;
  always @(posedge clkout_h) edges_h++;

  logic [1:0] trk_idx = 2'd0;
  wire        trk_src = src_clk[trk_idx];

  task automatic follow(input logic [1:0] idx, input bit which, input int n, input string tag);
    trk_idx = idx;
    #1;
    for (int i = 0; i < n; i++) begin
      @(posedge trk_src); #4;
      chk({tag, "_hi"}, which ? clkout_l : clkout_h, 1);
      @(negedge trk_src); #4;
      chk({tag, "_lo"}, which ? clkout_l : clkout_h, 0);
    end
  endtask

  task automatic req(input bit which, input logic [2:0] val);
    @(posedge hsclk); #1;
    if (which) begin
      sel_req_l = val[1:0];
      sel_valid_l = 1'b1;
    end else begin
      sel_req_h = val;
      sel_valid_h = 1'b1;
    end
    @(posedge hsclk); #1;
    sel_valid_h = 1'b0;
    sel_valid_l = 1'b0;
  endtask

  task automatic wait_done(input bit which, input int budget, input string tag);
    int n = 0;
    while (!(which ? done_l : done_h) && n < budget) begin
      @(posedge hsclk); #1;
      n++;
    end
    chk({tag, "_done"}, which ? done_l : done_h, 1);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    rst_h_b = 1'b0; rst_l_b = 1'b0;
    sel_valid_h = 1'b0; sel_valid_l = 1'b0;
    sel_req_h = '0; sel_req_l = '0;
    #55;
    rst_h_b = 1'b1; rst_l_b = 1'b1;

    @(posedge hsclk); #1;
    chk("rst_cur_h", cur_sel_h, 0);
    chk("rst_busy_h", busy_h, 0);
    chk("rst_ready_h", sel_ready_h, 1);
    chk("rst_done_h", done_h, 0);
    chk("rst_terr_h", terr_h, 0);
    chk("rst_cur_l", cur_sel_l, 0);
    chk("rst_ready_l", sel_ready_l, 1);
    follow(2'd0, 1'b0, 2, "rst_trk_h");
    follow(2'd0, 1'b1, 1, "rst_trk_l");

    // Park-high switch 0 -> 2.
    mon_start(1'b0);
    req(1'b0, 3'd2);
    chk("sw02_busy", busy_h, 1);
    chk("sw02_ready", sel_ready_h, 0);
    wait_done(1'b0, 100, "sw02");
    chk("sw02_cur", cur_sel_h, 2);
    chk("sw02_idle", busy_h, 0);
    @(posedge hsclk); #1;
    chk("sw02_pulse", done_h, 0);
    follow(2'd2, 1'b0, 2, "sw02_trk");
    mon_en = 1'b0;
    chk("sw02_min_phase", min_ph >= 9.999, 1);
    chk("sw02_park_high", max_hi > 150.0, 1);

    // Park-low switch 1 -> 3.
    req(1'b1, 3'd1);
    wait_done(1'b1, 100, "sw01l");
    chk("sw01l_cur", cur_sel_l, 1);
    mon_start(1'b1);
    req(1'b1, 3'd3);
    chk("sw13_busy", busy_l, 1);
    wait_done(1'b1, 300, "sw13");
    chk("sw13_cur", cur_sel_l, 3);
    follow(2'd3, 1'b1, 1, "sw13_trk");
    mon_en = 1'b0;
    chk("sw13_min_phase", min_ph >= 9.999, 1);
    chk("sw13_park_low", max_lo > 600.0, 1);

    // Dead clock: stop src_clk[2] while selected, then request 0.
    run2 = 1'b0;
    #300;
    req(1'b0, 3'd0);
    chk("tmo_busy", busy_h, 1);
    repeat (254) @(posedge hsclk);
    #1;
    chk("tmo_early", terr_h, 0);
    @(posedge hsclk); #1;
    chk("tmo_set", terr_h, 1);
    wait_done(1'b0, 50, "tmo");
    chk("tmo_cur", cur_sel_h, 0);
    e0 = edges_h;
    #400;
    chk("tmo_clk50", (edges_h - e0) inside {[19:21]}, 1);
    chk("tmo_sticky", terr_h, 1);

    // Request for the source already selected.
    req(1'b0, 3'd0);
    chk("same_done", done_h, 1);
    chk("same_busy", busy_h, 0);
    chk("same_ready", sel_ready_h, 1);
    @(posedge hsclk); #1;
    chk("same_pulse", done_h, 0);

    // Out-of-range index.
    req(1'b0, 3'd5);
    chk("oor_busy", busy_h, 0);
    chk("oor_done", done_h, 0);
    repeat (3) @(posedge hsclk);
    #1;
    chk("oor_cur", cur_sel_h, 0);

    // Request while busy is ignored.
    req(1'b0, 3'd3);
    chk("bsy_busy", busy_h, 1);
    sel_req_h = 3'd1;
    sel_valid_h = 1'b1;
    chk("bsy_ready", sel_ready_h, 0);
    @(posedge hsclk); #1;
    sel_valid_h = 1'b0;
    wait_done(1'b0, 300, "bsy");
    chk("bsy_cur", cur_sel_h, 3);

    // Reset in the middle of DROP.
    req(1'b0, 3'd0);
    repeat (5) @(posedge hsclk);
    #1;
    chk("mid_busy", busy_h, 1);
    rst_h_b = 1'b0;
    #1;
    chk("mid_rst_busy", busy_h, 0);
    chk("mid_rst_cur", cur_sel_h, 0);
    chk("mid_rst_terr", terr_h, 0);
    #40;
    rst_h_b = 1'b1;
    follow(2'd0, 1'b0, 3, "mid_trk");
    chk("mid_ready", sel_ready_h, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
